pdm_capture_ctrl: RTL and testbench

- Sequences the PDM microphone front end: holds the PDM clock divider in reset while idle, releases it on start, and waits out the microphone wake-up time.
- Then samples the PDM bit stream on each M_CLK rising-edge strobe and packs the bits into fixed-width words.
- Words are delivered through a single-entry valid/ready output register to the downstream decimation filter.
- Sits between the PDM clock divider and the filter/FIFO chain, in the system clock domain.

---
 rtl/pdm_capture_ctrl.sv | 147 ++++++++++++++
 tb/tb_pdm_capture_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/pdm_capture_ctrl.sv
// PDM capture sequencer: wakes the mic clock, samples the PDM stream on M_CLK
// rising strobes, and packs bits MSB-first into words behind a valid/ready register.
module pdm_capture_ctrl #(
  parameter int WORD_W     = 16,
  parameter int WAKE_EDGES = 25000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              m_clk_rising,
  input  logic              pdm_data,
  output logic              gen_rst,
  output logic [WORD_W-1:0] word_data,
  output logic              word_valid,
  input  logic              word_ready,
  output logic              busy,
  output logic              capturing,
  output logic              overflow,
  input  logic              clr_overflow
);
  localparam int WCW = $clog2(WAKE_EDGES + 1);
  localparam int BCW = $clog2(WORD_W);

  typedef enum logic [1:0] {IDLE, WAKE, CAPTURE} state_t;

  state_t             state_q, state_d;
  logic [WCW-1:0]     wake_cnt_q, wake_cnt_d;
  logic [BCW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [WORD_W-1:0]  shift_q, shift_d;
  logic               sync1_q, sync2_q;
  logic               gen_rst_q, gen_rst_d;
  logic [WORD_W-1:0]  word_data_q, word_data_d;
  logic               word_valid_q, word_valid_d;
  logic               busy_q, busy_d;
  logic               capturing_q, capturing_d;
  logic               overflow_q, overflow_d;

  logic               complete;
  logic [WORD_W-1:0]  new_word;

  assign new_word = {shift_q[WORD_W-2:0], sync2_q};

  always_comb begin
    state_d     = state_q;
    wake_cnt_d  = wake_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    complete    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !stop) begin
          state_d    = WAKE;
          wake_cnt_d = '0;
        end
      end
      WAKE: begin
        if (stop) begin
          state_d    = IDLE;
          wake_cnt_d = '0;
        end else if (m_clk_rising) begin
          wake_cnt_d = wake_cnt_q + 1'b1;
          if (wake_cnt_q == WCW'(WAKE_EDGES - 1)) begin
            state_d   = CAPTURE;
            bit_cnt_d = '0;
            shift_d   = '0;
          end
        end
      end
      CAPTURE: begin
        if (m_clk_rising) begin
          shift_d = new_word;
          if (bit_cnt_q == BCW'(WORD_W - 1)) begin
            complete  = 1'b1;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
        // A word completing on the stop strobe is still delivered below.
        if (stop) begin
          state_d    = IDLE;
          bit_cnt_d  = '0;
          shift_d    = '0;
          wake_cnt_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    gen_rst_d   = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
    capturing_d = (state_d == CAPTURE);

    word_data_d  = word_data_q;
    word_valid_d = word_valid_q;
    overflow_d   = overflow_q;
    if (clr_overflow) overflow_d = 1'b0;
    if (complete) begin
      if (!word_valid_q || word_ready) begin
        word_data_d  = new_word;
        word_valid_d = 1'b1;
      end else begin
        overflow_d = 1'b1;
      end
    end else if (word_valid_q && word_ready) begin
      word_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      wake_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      gen_rst_q    <= 1'b1;
      word_data_q  <= '0;
      word_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      capturing_q  <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wake_cnt_q   <= wake_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      sync1_q      <= pdm_data;
      sync2_q      <= sync1_q;
      gen_rst_q    <= gen_rst_d;
      word_data_q  <= word_data_d;
      word_valid_q <= word_valid_d;
      busy_q       <= busy_d;
      capturing_q  <= capturing_d;
      overflow_q   <= overflow_d;
    end
  end

  assign gen_rst    = gen_rst_q;
  assign word_data  = word_data_q;
  assign word_valid = word_valid_q;
  assign busy       = busy_q;
  assign capturing  = capturing_q;
  assign overflow   = overflow_q;
endmodule

// File: tb/tb_pdm_capture_ctrl.sv
// Scoreboard bench for pdm_capture_ctrl: expected words are queued as bits are
// fed and popped by a monitor on every valid/ready transfer.
module tb_pdm_capture_ctrl;
  localparam int WORD_W     = 8;
  localparam int WAKE_EDGES = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0, stop = 1'b0, m_clk_rising = 1'b0, pdm_data = 1'b0;
  logic              word_ready = 1'b1, clr_overflow = 1'b0;
  logic              gen_rst, word_valid, busy, capturing, overflow;
  logic [WORD_W-1:0] word_data;

  int n_cmp = 0;
  int n_err = 0;
  logic [WORD_W-1:0] sb[$];

  pdm_capture_ctrl #(.WORD_W(WORD_W), .WAKE_EDGES(WAKE_EDGES)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .m_clk_rising(m_clk_rising), .pdm_data(pdm_data), .gen_rst(gen_rst),
    .word_data(word_data), .word_valid(word_valid), .word_ready(word_ready),
    .busy(busy), .capturing(capturing), .overflow(overflow),
    .clr_overflow(clr_overflow)
  );

  always #5 clk = ~clk;

  // Transfer monitor: every accepted word must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && word_valid && word_ready) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL xfer_unexpected: got %h, required none", word_data);
      end else begin
        logic [WORD_W-1:0] exp_w;
        exp_w = sb.pop_front();
        if (word_data !== exp_w) begin
          n_err++;
          $display("FAIL xfer_data: got %h, required %h", word_data, exp_w);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // One M_CLK period: data settles well ahead of the 1-cycle strobe.
  task automatic strobe(input logic b, input logic with_stop);
    pdm_data = b;
    tick(39);
    m_clk_rising = 1'b1;
    stop = with_stop;
    tick(1);
    m_clk_rising = 1'b0;
    stop = 1'b0;
  endtask

  task automatic send_word(input logic [WORD_W-1:0] w, input bit push);
    if (push) sb.push_back(w);
    for (int i = WORD_W - 1; i >= 0; i--) strobe(w[i], 1'b0);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  task automatic start_and_wake();
    n_cmp++;
    if (gen_rst !== 1'b1) begin n_err++; $display("FAIL pre_start_gen_rst: got %b, required 1", gen_rst); end
    start = 1'b1;
    tick(1);
    start = 1'b0;
    n_cmp++;
    if (gen_rst !== 1'b0 || busy !== 1'b1 || capturing !== 1'b0) begin
      n_err++;
      $display("FAIL wake_entry: gen_rst=%b busy=%b capturing=%b, required 0 1 0", gen_rst, busy, capturing);
    end
    for (int i = 0; i < WAKE_EDGES; i++) begin
      strobe(1'($urandom_range(0, 1)), 1'b0);
      n_cmp++;
      if (capturing !== (i == WAKE_EDGES - 1) || word_valid !== 1'b0) begin
        n_err++;
        $display("FAIL wake_edge%0d: capturing=%b word_valid=%b, required %b 0", i, capturing, word_valid, i == WAKE_EDGES - 1);
      end
    end
  endtask

  task automatic test_reset();
    tick(2);
    n_cmp++;
    if (gen_rst !== 1'b1 || word_valid !== 1'b0 || word_data !== '0 || busy !== 1'b0 ||
        capturing !== 1'b0 || overflow !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: gen_rst=%b valid=%b data=%h busy=%b cap=%b ovf=%b", gen_rst, word_valid, word_data, busy, capturing, overflow);
    end
    rst_n = 1'b1;
    tick(2);
    chk("idle_after_reset_busy", {31'd0, busy}, 32'd0);
  endtask

  task automatic test_word();
    word_ready = 1'b1;
    start_and_wake();
    send_word(8'hA5, 1'b1);
    chk("word_valid_rise", {31'd0, word_valid}, 32'd1);
    chk("word_data_a5", {24'd0, word_data}, 32'hA5);
    tick(1);
    chk("word_valid_one_cycle", {31'd0, word_valid}, 32'd0);
  endtask

  task automatic test_overflow();
    word_ready = 1'b0;
    send_word(8'hA5, 1'b1);
    chk("hold_valid", {31'd0, word_valid}, 32'd1);
    send_word(8'h3C, 1'b0);
    chk("hold_data", {24'd0, word_data}, 32'hA5);
    chk("overflow_set", {31'd0, overflow}, 32'd1);
    chk("hold_valid2", {31'd0, word_valid}, 32'd1);
    word_ready = 1'b1;
    tick(1);
    chk("drain_valid", {31'd0, word_valid}, 32'd0);
    chk("overflow_sticky", {31'd0, overflow}, 32'd1);
    clr_overflow = 1'b1;
    tick(1);
    clr_overflow = 1'b0;
    chk("overflow_clr", {31'd0, overflow}, 32'd0);
  endtask

  task automatic test_stop_partial();
    strobe(1'b1, 1'b0); strobe(1'b1, 1'b0); strobe(1'b0, 1'b0);
    strobe(1'b1, 1'b0); strobe(1'b0, 1'b0);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    n_cmp++;
    if (gen_rst !== 1'b1 || busy !== 1'b0 || capturing !== 1'b0 || word_valid !== 1'b0) begin
      n_err++;
      $display("FAIL stop_partial: gen_rst=%b busy=%b cap=%b valid=%b, required 1 0 0 0", gen_rst, busy, capturing, word_valid);
    end
    for (int i = 0; i < 3; i++) strobe(1'b1, 1'b0);
    chk("idle_ignores_strobe", {30'd0, busy, word_valid}, 32'd0);
    start_and_wake();
    send_word(8'hFF, 1'b1);
    chk("restart_data_ff", {24'd0, word_data}, 32'hFF);
    chk("restart_valid", {31'd0, word_valid}, 32'd1);
    tick(1);
  endtask

  task automatic test_start_stop_same();
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    chk("stop_to_idle", {31'd0, busy}, 32'd0);
    start = 1'b1; stop = 1'b1;
    tick(1);
    start = 1'b0; stop = 1'b0;
    tick(2);
    chk("start_stop_idle", {30'd0, busy, gen_rst}, 32'd1);
  endtask

  task automatic test_stop_on_complete();
    logic [WORD_W-1:0] w;
    w = 8'h69;
    start_and_wake();
    sb.push_back(w);
    for (int i = WORD_W - 1; i >= 1; i--) strobe(w[i], 1'b0);
    strobe(w[0], 1'b1);
    n_cmp++;
    if (word_valid !== 1'b1 || word_data !== w || capturing !== 1'b0 || gen_rst !== 1'b1) begin
      n_err++;
      $display("FAIL stop_on_complete: valid=%b data=%h cap=%b gen_rst=%b, required 1 %h 0 1", word_valid, word_data, capturing, gen_rst, w);
    end
    tick(1);
  endtask

  task automatic test_async_reset();
    word_ready = 1'b0;
    start_and_wake();
    send_word(8'h5A, 1'b0);
    send_word(8'h11, 1'b0);
    chk("pre_reset_valid_ovf", {30'd0, word_valid, overflow}, 32'd3);
    #3 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (gen_rst !== 1'b1 || word_valid !== 1'b0 || word_data !== '0 || busy !== 1'b0 ||
        capturing !== 1'b0 || overflow !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset: gen_rst=%b valid=%b data=%h busy=%b cap=%b ovf=%b", gen_rst, word_valid, word_data, busy, capturing, overflow);
    end
    tick(2);
    rst_n = 1'b1;
    word_ready = 1'b1;
    strobe(1'b1, 1'b0);
    chk("post_reset_idle", {29'd0, busy, capturing, gen_rst}, 32'd1);
  endtask

  initial begin
    test_reset();
    test_word();
    test_overflow();
    test_stop_partial();
    test_start_stop_same();
    test_stop_on_complete();
    test_async_reset();
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
